// File: rtl/btn_cmd_pkg.sv
// Shared constants and helpers for the button command queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: BTN_CODE_W default code width, clog2_f constant helper,
// prio_enc lowest-set-bit encoder used by the push arbiter.
package btn_cmd_pkg;

   localparam int BTN_NUM    = 4;
   localparam int BTN_CODE_W = 2;

   // Result of a priority encode: index of the lowest set bit and whether any bit was set.
   typedef struct packed {
      logic       found;
      logic [7:0] idx;
   } penc_t;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Lowest set bit wins. Scanning from the top down lets the last hit be the lowest index.
   function automatic penc_t prio_enc(input logic [31:0] vec);
      penc_t r;
      r.found = 1'b0;
      r.idx   = 8'd0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) begin
            r.found = 1'b1;
            r.idx   = 8'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_cmd_fifo.sv
// Small synchronous FIFO holding command codes; head is read combinationally.
// Latency: a pushed entry is visible at the head one clock after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
//
// Ports: clk_entrada/reset (async active-high), push + wr_dat, pop, rd_dat (head, 0 when empty),
//        full, empty, count (entries held, 0..DEPTH).
module btn_cmd_fifo
   import btn_cmd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic                    clk_entrada,
   input  logic                    reset,
   input  logic                    push,
   input  logic [W-1:0]            wr_dat,
   input  logic                    pop,
   output logic [W-1:0]            rd_dat,
   output logic                    full,
   output logic                    empty,
   output logic [clog2_f(DEPTH):0] count
);

   localparam int AW = clog2_f(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_do;
   logic          pop_do;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_do  = pop & ~empty;
   // A pop in the same cycle frees the slot being written, so a full FIFO can still accept.
   assign push_do = push & (~full | pop_do);

   // Masked while empty so a stale entry never shows on the output.
   assign rd_dat  = empty ? '0 : mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_entrada or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_do) wr_ptr <= wr_ptr + 1'b1;
         if (pop_do)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_do, pop_do})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_entrada) begin
      if (push_do) mem[wr_ptr] <= wr_dat;
   end

endmodule

// File: rtl/button_cmd_queue.sv
// Turns debounced button pulses into queued command codes (code = button index).
// Latency: input high sampled at edge N -> cmd_valid after edge N+3 (empty FIFO, no lower index pending).
// Backpressure: cmd_valid/cmd_ready; presses wait in a per-button pending bit, a repeat press on a
//               still-pending button is dropped and flagged on the sticky overflow output.
//
// Ports: clk_entrada, reset (async active-high), sinal_estavel[NUM_BTN] (async pulses),
//        cmd_valid/cmd_code/cmd_ready (head of queue), fifo_count, overflow (sticky until reset).
// Optional: define BTN_DROP_COUNT_EN to add drop_count[7:0], a saturating count of dropped presses.
module button_cmd_queue
   import btn_cmd_pkg::*;
#(
   parameter int NUM_BTN = BTN_NUM,
   parameter int DEPTH   = 4,
   parameter int CODE_W  = BTN_CODE_W
) (
   input  logic                    clk_entrada,
   input  logic                    reset,
   input  logic [NUM_BTN-1:0]      sinal_estavel,
   output logic                    cmd_valid,
   output logic [CODE_W-1:0]       cmd_code,
   input  logic                    cmd_ready,
   output logic [clog2_f(DEPTH):0] fifo_count,
   output logic                    overflow
`ifdef BTN_DROP_COUNT_EN
   ,
   output logic [7:0]              drop_count
`endif
);

   logic [NUM_BTN-1:0] s1;
   logic [NUM_BTN-1:0] s2;
   logic [NUM_BTN-1:0] s3;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] pending;
   logic [NUM_BTN-1:0] clr;
   logic [NUM_BTN-1:0] drop;
   penc_t              pe;
   logic [CODE_W-1:0]  push_code;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;

   // s1/s2 form the synchroniser; s3 only delays s2 for edge detection.
   always_ff @(posedge clk_entrada or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= sinal_estavel;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // Arbiter: the lowest pending button goes into the FIFO whenever a slot is free this cycle.
   assign pe        = prio_enc(32'(pending));
   assign push_code = CODE_W'(pe.idx);
   assign pop       = cmd_valid & cmd_ready;
   assign push      = pe.found & (~full | pop);

   always_comb begin
      clr = '0;
      if (push) clr[push_code] = 1'b1;
   end

   // A fresh edge on a bit that is still waiting (and not leaving this cycle) has nowhere to go.
   assign drop = rise & pending & ~clr;

   always_ff @(posedge clk_entrada or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         pending  <= (pending & ~clr) | rise;
         overflow <= overflow | (|drop);
      end
   end

`ifdef BTN_DROP_COUNT_EN
   // Nine bits leave headroom for several drops landing on top of 255 before clamping.
   logic [8:0] drop_sum;

   always_comb begin
      drop_sum = {1'b0, drop_count};
      for (int i = 0; i < NUM_BTN; i++) begin
         drop_sum = drop_sum + {8'd0, drop[i]};
      end
   end

   always_ff @(posedge clk_entrada or posedge reset) begin
      if (reset) begin
         drop_count <= 8'd0;
      end else begin
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end
`endif

   btn_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CODE_W)
   ) u_fifo (
      .clk_entrada (clk_entrada),
      .reset       (reset),
      .push        (push),
      .wr_dat      (push_code),
      .pop         (pop),
      .rd_dat      (cmd_code),
      .full        (full),
      .empty       (empty),
      .count       (fifo_count)
   );

   assign cmd_valid = ~empty;

endmodule

// File: tb/tb_button_cmd_queue.sv
// Directed bench for button_cmd_queue: per-cycle vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: cmd_ready driven directly from the vectors and sequences.
module tb_button_cmd_queue;

   logic       clk_entrada = 1'b0;
   logic       reset;
   logic [3:0] sinal_estavel;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic       cmd_ready;
   logic [2:0] fifo_count;
   logic       overflow;
`ifdef BTN_DROP_COUNT_EN
   logic [7:0] drop_count;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [3:0] sig;
      logic       rdy;
      logic       vld;
      logic [1:0] code;
      logic [2:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t tbl[$];

   button_cmd_queue #(
      .NUM_BTN (4),
      .DEPTH   (4),
      .CODE_W  (2)
   ) dut (
      .clk_entrada   (clk_entrada),
      .reset         (reset),
      .sinal_estavel (sinal_estavel),
      .cmd_valid     (cmd_valid),
      .cmd_code      (cmd_code),
      .cmd_ready     (cmd_ready),
      .fifo_count    (fifo_count),
      .overflow      (overflow)
`ifdef BTN_DROP_COUNT_EN
      ,
      .drop_count    (drop_count)
`endif
   );

   always #5 clk_entrada = ~clk_entrada;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic add(input logic [3:0] sig, input logic rdy, input logic vld,
                      input logic [1:0] code, input logic [2:0] cnt, input logic ovf);
      vec_t v;
      v.sig = sig; v.rdy = rdy; v.vld = vld; v.code = code; v.cnt = cnt; v.ovf = ovf;
      tbl.push_back(v);
   endtask

   // One-cycle pulse on button b, then idle long enough for it to reach the FIFO if it can.
   task automatic pulse(input int b);
      @(negedge clk_entrada);
      sinal_estavel = 4'(1 << b);
      @(negedge clk_entrada);
      sinal_estavel = 4'b0000;
      repeat (5) @(negedge clk_entrada);
   endtask

   task automatic ready_one_cycle();
      @(negedge clk_entrada);
      cmd_ready = 1'b1;
      @(negedge clk_entrada);
      cmd_ready = 1'b0;
   endtask

   initial begin
      // Row k: inputs applied at the negedge before edge k; outputs checked reflect edge k-1.
      // Bit 2 high for five cycles, consumer always ready: exactly one code 2, one cycle long.
      for (int k = 0; k < 4; k++) add(4'b0100, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
      add(4'b0100, 1'b1, 1'b1, 2'd2, 3'd1, 1'b0);
      for (int k = 0; k < 5; k++) add(4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
      // Bits 3 and 1 together with consumer stalled: queued as 1 then 3, drained in order.
      add(4'b1010, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
      for (int k = 0; k < 3; k++) add(4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
      add(4'b0000, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0);
      add(4'b0000, 1'b0, 1'b1, 2'd1, 3'd2, 1'b0);
      add(4'b0000, 1'b1, 1'b1, 2'd1, 3'd2, 1'b0);
      add(4'b0000, 1'b1, 1'b1, 2'd3, 3'd1, 1'b0);
      add(4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
      add(4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);

      reset         = 1'b1;
      sinal_estavel = 4'b0000;
      cmd_ready     = 1'b0;
      repeat (3) @(negedge clk_entrada);
      chk("rst_vld", int'(cmd_valid), 0);
      chk("rst_cnt", int'(fifo_count), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_code", int'(cmd_code), 0);
      reset = 1'b0;
      @(negedge clk_entrada);
      chk("post_rst_vld", int'(cmd_valid), 0);
      chk("post_rst_cnt", int'(fifo_count), 0);
`ifdef BTN_DROP_COUNT_EN
      chk("rst_drop_count", int'(drop_count), 0);
`endif

      foreach (tbl[k]) begin
         @(negedge clk_entrada);
         sinal_estavel = tbl[k].sig;
         cmd_ready     = tbl[k].rdy;
         chk($sformatf("row%0d_vld", k), int'(cmd_valid), int'(tbl[k].vld));
         chk($sformatf("row%0d_code", k), int'(cmd_code), int'(tbl[k].code));
         chk($sformatf("row%0d_cnt", k), int'(fifo_count), int'(tbl[k].cnt));
         chk($sformatf("row%0d_ovf", k), int'(overflow), int'(tbl[k].ovf));
      end

      // Fill: four presses fill the FIFO, two more wait in pending bits 0 and 1.
      @(negedge clk_entrada);
      sinal_estavel = 4'b0000;
      cmd_ready     = 1'b0;
      for (int b = 0; b < 4; b++) pulse(b);
      chk("fill_cnt", int'(fifo_count), 4);
      chk("fill_head", int'(cmd_code), 0);
      chk("fill_vld", int'(cmd_valid), 1);
      pulse(0);
      pulse(1);
      chk("pend_cnt", int'(fifo_count), 4);
      chk("pend_ovf", int'(overflow), 0);
      // Repeat press on still-pending bit 0 is dropped.
      pulse(0);
      chk("drop_ovf", int'(overflow), 1);
      chk("drop_cnt", int'(fifo_count), 4);
`ifdef BTN_DROP_COUNT_EN
      chk("drop_count", int'(drop_count), 1);
`endif

      // Full FIFO, pop and push together: count holds, head advances 0 -> 1 -> 2.
      ready_one_cycle();
      chk("pp1_cnt", int'(fifo_count), 4);
      chk("pp1_head", int'(cmd_code), 1);
      repeat (2) @(negedge clk_entrada);
      chk("pp1_hold_cnt", int'(fifo_count), 4);
      chk("pp1_hold_head", int'(cmd_code), 1);
      ready_one_cycle();
      chk("pp2_cnt", int'(fifo_count), 4);
      chk("pp2_head", int'(cmd_code), 2);
      chk("ovf_sticky", int'(overflow), 1);

      // Queue now 2,3,0,1 with nothing pending; pop one to leave 3 queued.
      ready_one_cycle();
      chk("q3_cnt", int'(fifo_count), 3);
      chk("q3_head", int'(cmd_code), 3);

      // Press bit 2 and reset while it sits in pending (set at edge 2, push would be edge 3).
      @(negedge clk_entrada);
      sinal_estavel = 4'b0100;
      @(posedge clk_entrada);
      @(negedge clk_entrada);
      sinal_estavel = 4'b0000;
      @(posedge clk_entrada);
      @(posedge clk_entrada);
      #2;
      chk("prerst_cnt", int'(fifo_count), 3);
      reset = 1'b1;
      #1;
      chk("arst_vld", int'(cmd_valid), 0);
      chk("arst_cnt", int'(fifo_count), 0);
      chk("arst_code", int'(cmd_code), 0);
      chk("arst_ovf", int'(overflow), 0);
`ifdef BTN_DROP_COUNT_EN
      chk("arst_drop_count", int'(drop_count), 0);
`endif
      repeat (2) @(negedge clk_entrada);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_entrada);
         chk($sformatf("after_rst%0d_vld", k), int'(cmd_valid), 0);
         chk($sformatf("after_rst%0d_cnt", k), int'(fifo_count), 0);
      end

      // Queue still usable after reset.
      pulse(3);
      chk("reuse_vld", int'(cmd_valid), 1);
      chk("reuse_code", int'(cmd_code), 3);
      chk("reuse_cnt", int'(fifo_count), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
